// File: rtl/register_file.sv
// register_file: RV64 integer register file, 32 x 64 bits, x0 hardwired to zero; registered reads.
// Optional REGFILE_BYPASS_EN selects write-first on a same-edge read/write collision (default read-first).
`default_nettype none

module register_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  output logic [XLEN-1:0] data1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] data2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            we
);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] read1_next;
  logic [XLEN-1:0] read2_next;
  logic            write_live;

  // A write to x0 is treated as no write at all, so it can neither land nor bypass.
  assign write_live = we && (rd != '0);

  always_comb begin
    read1_next = (rs1 == '0) ? '0 : regs[rs1];
    read2_next = (rs2 == '0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
    if (write_live && (rs1 == rd)) read1_next = write_data;
    if (write_live && (rs2 == rd)) read2_next = write_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      data1 <= '0;
      data2 <= '0;
    end else begin
      if (write_live) regs[rd] <= write_data;
      data1 <= read1_next;
      data2 <= read2_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic against an array model.
`default_nettype none

module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] data1, data2, write_data;
  logic        we;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [32];

  register_file dut (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .data1      (data1),
    .rs2        (rs2),
    .data2      (data2),
    .rd         (rd),
    .write_data (write_data),
    .we         (we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value a read port should return given the register state before this edge.
  function automatic logic [63:0] model_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] d, input logic [63:0] wd);
    if (a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (w && d != 5'd0 && a == d) return wd;
`endif
    return model[a];
  endfunction

  task automatic cycle(input string tag, input logic r, input logic w, input logic [4:0] d,
                       input logic [63:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    logic [63:0] e1, e2;
    reset = r; we = w; rd = d; write_data = wd; rs1 = a1; rs2 = a2;
    if (r) begin
      e1 = 64'd0;
      e2 = 64'd0;
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else begin
      e1 = model_read(a1, w, d, wd);
      e2 = model_read(a2, w, d, wd);
      if (w && d != 5'd0) model[d] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "/data1"}, data1, e1);
    check({tag, "/data2"}, data2, e2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    reset = 1'b1; we = 1'b0; rd = '0; rs1 = '0; rs2 = '0; write_data = '0;

    cycle("reset_init", 1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

    // Contents are lost on reset.
    cycle("rst_wr", 1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd0);
    cycle("rst_pre", 1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    cycle("rst_pulse", 1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    cycle("rst_read", 1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);

    cycle("basic_wr", 1'b0, 1'b1, 5'd10, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    cycle("basic_rd", 1'b0, 1'b0, 5'd0, 64'd0, 5'd10, 5'd0);

    cycle("x0_wr", 1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    cycle("x0_rd", 1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

    cycle("coll_setup", 1'b0, 1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    cycle("coll_edge", 1'b0, 1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
    cycle("coll_after", 1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);

    for (int i = 1; i < 32; i++)
      cycle("sweep_wr", 1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 5'(i - 1), 5'(32 - i));
    for (int i = 0; i < 32; i++)
      cycle("sweep_rd", 1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));

    cycle("rst_vs_wr", 1'b1, 1'b1, 5'd3, 64'h55, 5'd3, 5'd3);
    cycle("rst_vs_wr_rd", 1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);

    for (int n = 0; n < 600; n++) begin
      logic        r, w;
      logic [4:0]  d, a1, a2;
      logic [63:0] wd;
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 2) != 0);
      d  = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      cycle("random", r, w, d, wd, a1, a2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
